sd_spi_xfer_sched: RTL and testbench

Sector-transfer scheduler in front of the SD SPI read/write controller.
- Two requesters (e.g. data logger and readback checker) each post single-sector read or write jobs.
- The block arbitrates round-robin between them, issues one-cycle start pulses with a stable sector address, and tracks the controller's busy handshake to completion.
- Each job reports back to its requester as either done or error.

---
 rtl/sd_spi_pkg.sv | 23 ++
 rtl/sd_spi_rr_arb2.sv | 29 ++
 rtl/sd_spi_xfer_sched.sv | 172 +++++++++++++++++
 tb/tb_sd_spi_xfer_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared constants for the SD SPI transfer scheduler: FSM encoding,
// default timing limits and the sector address used by the data generator.
package sd_spi_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_XFER      = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_ERR       = 3'd5;

  localparam int START_WAIT_DEF     = 16;
  localparam int TIMEOUT_CYCLES_DEF = 5_000_000;
  localparam int CNT_W_DEF          = 23;

  localparam logic [31:0] TEST_SEC_ADDR = 32'd2000;

  // States in which a job is in flight with the controller.
  function automatic logic is_job_state(input logic [2:0] st);
    return (st == ST_ISSUE) || (st == ST_WAIT_BUSY) || (st == ST_XFER);
  endfunction

endpackage

// File: rtl/sd_spi_rr_arb2.sv
// Two-input round-robin grant. The last winner is remembered only when the
// scheduler finishes a job, so a tie always favours the other requester.
module sd_spi_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic update,
  input  logic update_id,
  output logic grant_valid,
  output logic grant_id
);

  logic last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= update_id;
    end
  end

  always_comb begin
    grant_valid = valid0 | valid1;
    grant_id    = (valid0 & valid1) ? ~last_grant : valid1;
  end

endmodule

// File: rtl/sd_spi_xfer_sched.sv
// Sector-transfer scheduler: arbitrates two job requesters onto the SD SPI
// read/write controller and follows its busy handshake to done or error.
module sd_spi_xfer_sched
  import sd_spi_pkg::*;
#(
  parameter int START_WAIT     = START_WAIT_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic        clk_50m,
  input  logic        reset_n,
  input  logic        sd_init_done,
  input  logic        req0_valid,
  input  logic        req0_wr,
  input  logic [31:0] req0_sec_addr,
  output logic        req0_ready,
  output logic        req0_done,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic        req1_wr,
  input  logic [31:0] req1_sec_addr,
  output logic        req1_ready,
  output logic        req1_done,
  output logic        req1_err,
  input  logic        wr_busy,
  input  logic        rd_busy,
  output logic        wr_start_en,
  output logic [31:0] wr_sec_addr,
  output logic        rd_start_en,
  output logic [31:0] rd_sec_addr,
  output logic        error_flag
);

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_WAIT - 1);
  localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [2:0]       state_reg;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             cap_id_reg;
  logic             cap_wr_reg;
  logic             wr_busy_q;
  logic             rd_busy_q;
  logic             busy_q;
  logic [31:0]      wr_addr_reg;
  logic [31:0]      rd_addr_reg;
  logic             err_flag_reg;

  logic             grant_valid;
  logic             grant_id;
  logic             handshake;
  logic             sel_wr;
  logic [31:0]      sel_addr;
  logic             job_end;

  assign job_end = (state_reg == ST_DONE) || (state_reg == ST_ERR);

  sd_spi_rr_arb2 u_arb (
    .clk         (clk_50m),
    .rst_n       (reset_n),
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .update      (job_end),
    .update_id   (cap_id_reg),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    handshake  = (state_reg == ST_IDLE) & sd_init_done & grant_valid;
    req0_ready = handshake & ~grant_id;
    req1_ready = handshake &  grant_id;
    sel_wr     = grant_id ? req1_wr : req0_wr;
    sel_addr   = grant_id ? req1_sec_addr : req0_sec_addr;
    busy_q     = cap_wr_reg ? wr_busy_q : rd_busy_q;
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (handshake) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        cnt_next   = '0;
        state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (busy_q) begin
          state_next = ST_XFER;
          cnt_next   = '0;
        end else if (cnt_reg == START_LAST) begin
          state_next = ST_ERR;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_XFER: begin
        if (!busy_q) begin
          state_next = ST_DONE;
        end else if (cnt_reg == XFER_LAST) begin
          state_next = ST_ERR;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // Losing the card mid-job overrides every busy/counter outcome.
    if (is_job_state(state_reg) && !sd_init_done) begin
      state_next = ST_ERR;
    end
  end

  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      wr_busy_q <= 1'b0;
      rd_busy_q <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wr_busy_q <= wr_busy;
      rd_busy_q <= rd_busy;
    end
  end

  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      cap_id_reg  <= 1'b0;
      cap_wr_reg  <= 1'b0;
      wr_addr_reg <= '0;
      rd_addr_reg <= '0;
    end else if (handshake) begin
      cap_id_reg <= grant_id;
      cap_wr_reg <= sel_wr;
      if (sel_wr) begin
        wr_addr_reg <= sel_addr;
      end else begin
        rd_addr_reg <= sel_addr;
      end
    end
  end

  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      err_flag_reg <= 1'b0;
    end else if (state_reg == ST_ERR) begin
      err_flag_reg <= 1'b1;
    end
  end

  // Pulses decode straight from the state register, so reset clears them at once.
  always_comb begin
    wr_start_en = (state_reg == ST_ISSUE) &  cap_wr_reg;
    rd_start_en = (state_reg == ST_ISSUE) & ~cap_wr_reg;
    req0_done   = (state_reg == ST_DONE)  & ~cap_id_reg;
    req1_done   = (state_reg == ST_DONE)  &  cap_id_reg;
    req0_err    = (state_reg == ST_ERR)   & ~cap_id_reg;
    req1_err    = (state_reg == ST_ERR)   &  cap_id_reg;
    wr_sec_addr = wr_addr_reg;
    rd_sec_addr = rd_addr_reg;
    error_flag  = err_flag_reg;
  end

endmodule

// File: tb/tb_sd_spi_xfer_sched.sv
// Bench for sd_spi_xfer_sched: a job-level model predicts grant order, start
// cycles and done/err cycles from the timing rules; tables and sequences drive it.
module tb_sd_spi_xfer_sched;
  import sd_spi_pkg::*;

  localparam int SW = 16;
  localparam int TO = 50;

  logic        clk_50m = 1'b0;
  logic        reset_n = 1'b0;
  logic        sd_init_done = 1'b0;
  logic        req0_valid = 1'b0, req0_wr = 1'b0;
  logic [31:0] req0_sec_addr = '0;
  logic        req1_valid = 1'b0, req1_wr = 1'b0;
  logic [31:0] req1_sec_addr = '0;
  logic        req0_ready, req0_done, req0_err;
  logic        req1_ready, req1_done, req1_err;
  logic        wr_busy = 1'b0, rd_busy = 1'b0;
  logic        wr_start_en, rd_start_en, error_flag;
  logic [31:0] wr_sec_addr, rd_sec_addr;

  always #10 clk_50m = ~clk_50m;

  sd_spi_xfer_sched #(.START_WAIT(SW), .TIMEOUT_CYCLES(TO), .CNT_W(23)) dut (
    .clk_50m(clk_50m), .reset_n(reset_n), .sd_init_done(sd_init_done),
    .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_sec_addr(req0_sec_addr),
    .req0_ready(req0_ready), .req0_done(req0_done), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_sec_addr(req1_sec_addr),
    .req1_ready(req1_ready), .req1_done(req1_done), .req1_err(req1_err),
    .wr_busy(wr_busy), .rd_busy(rd_busy),
    .wr_start_en(wr_start_en), .wr_sec_addr(wr_sec_addr),
    .rd_start_en(rd_start_en), .rd_sec_addr(rd_sec_addr),
    .error_flag(error_flag)
  );

  typedef struct { logic wr; logic [31:0] addr; } job_t;
  typedef struct {
    bit v0; logic wr0; logic [31:0] a0;
    bit v1; logic wr1; logic [31:0] a1;
    int d; int l; int exp_first; bit exp_err; bit exp_flag;
  } vec_t;

  job_t q0[$], q1[$];
  int   acc_log[$];
  bit   out_err[$];
  int   checks = 0, failures = 0;
  int   n = 0;
  bit   init_cfg = 1'b0;
  int   cfg_d = 4, cfg_l = 5;
  bit   rand_busy = 1'b0;

  // job-level reference state
  bit m_active = 0, m_wr = 0, m_err = 0, m_last = 1, m_sticky = 0;
  int m_id = 0, m_s = 0, m_e = 0, m_d = 0, m_l = 0;
  logic [31:0] m_wa = '0, m_ra = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, n, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0b expected=%0b", name, n, act, exp);
    end
  endtask

  // Outcome from the rules: busy sampled high from S+d for l cycles.
  task automatic predict(input int s, input int d, input int l);
    if (d > SW - 1) begin
      m_e = s + SW + 1; m_err = 1;
    end else if (l > TO) begin
      m_e = s + d + TO + 2; m_err = 1;
    end else begin
      m_e = s + d + l + 2; m_err = 0;
    end
  endtask

  task automatic cyc();
    bit b, er0, er1;
    job_t j;
    @(posedge clk_50m);
    #1;
    n++;
    sd_init_done = init_cfg;
    req0_valid = (q0.size() > 0);
    if (req0_valid) begin req0_wr = q0[0].wr; req0_sec_addr = q0[0].addr; end
    req1_valid = (q1.size() > 0);
    if (req1_valid) begin req1_wr = q1[0].wr; req1_sec_addr = q1[0].addr; end
    b = m_active && (n >= m_s + m_d) && (n <= m_s + m_d + m_l - 1) && (n <= m_e);
    if (m_wr) begin wr_busy = b; rd_busy = 1'($urandom_range(0, 1)); end
    else      begin rd_busy = b; wr_busy = 1'($urandom_range(0, 1)); end
    @(negedge clk_50m);
    if (m_active && n > m_e) begin m_active = 0; m_last = (m_id == 1); end
    er0 = !m_active && init_cfg && req0_valid && (!req1_valid || m_last);
    er1 = !m_active && init_cfg && req1_valid && (!req0_valid || !m_last);
    chk1("req0_ready", req0_ready, er0);
    chk1("req1_ready", req1_ready, er1);
    chk1("wr_start_en", wr_start_en, m_active && n == m_s && m_wr);
    chk1("rd_start_en", rd_start_en, m_active && n == m_s && !m_wr);
    chk1("req0_done", req0_done, m_active && n == m_e && !m_err && m_id == 0);
    chk1("req1_done", req1_done, m_active && n == m_e && !m_err && m_id == 1);
    chk1("req0_err", req0_err, m_active && n == m_e && m_err && m_id == 0);
    chk1("req1_err", req1_err, m_active && n == m_e && m_err && m_id == 1);
    chk1("error_flag", error_flag, m_sticky);
    chk("wr_sec_addr", wr_sec_addr, m_wa);
    chk("rd_sec_addr", rd_sec_addr, m_ra);
    if (req0_done || req0_err) out_err.push_back(req0_err);
    if (req1_done || req1_err) out_err.push_back(req1_err);
    if (m_active && n == m_e && m_err) m_sticky = 1;
    if (m_active && !init_cfg && n >= m_s && n < m_e) begin m_e = n + 1; m_err = 1; end
    if (er0 || er1) begin
      m_id = er1 ? 1 : 0;
      j = er1 ? q1.pop_front() : q0.pop_front();
      m_active = 1; m_wr = j.wr; m_s = n + 1;
      if (j.wr) m_wa = j.addr; else m_ra = j.addr;
      if (rand_busy) begin m_d = $urandom_range(0, 18); m_l = $urandom_range(1, 55); end
      else begin m_d = cfg_d; m_l = cfg_l; end
      predict(m_s, m_d, m_l);
      acc_log.push_back(m_id);
      $display("ACCEPT req%0d wr=%0b addr=%0d cycle=%0d d=%0d l=%0d expect_%s_at=%0d",
               m_id, j.wr, j.addr, n, m_d, m_l, m_err ? "err" : "done", m_e);
    end
  endtask

  task automatic drain(input int maxc);
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_active) && k < maxc) begin
      cyc();
      k++;
    end
    chk1("drain_bound", k < maxc, 1'b1);
  endtask

  task automatic push(input int id, input logic wr, input logic [31:0] addr);
    job_t j;
    j.wr = wr; j.addr = addr;
    if (id == 1) q1.push_back(j); else q0.push_back(j);
  endtask

  vec_t vecs[6];
  int   alt_exp[4];

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", n);
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk_50m);
    #1;
    chk1("rst_wr_start", wr_start_en, 1'b0);
    chk1("rst_rd_start", rd_start_en, 1'b0);
    chk1("rst_done_err", req0_done | req1_done | req0_err | req1_err, 1'b0);
    chk1("rst_error_flag", error_flag, 1'b0);
    chk("rst_wr_addr", wr_sec_addr, 32'd0);
    chk("rst_rd_addr", rd_sec_addr, 32'd0);
    @(negedge clk_50m);
    reset_n = 1'b1;

    // Card not ready: valid held, nothing may be granted
    init_cfg = 0;
    push(0, 1'b1, TEST_SEC_ADDR);
    repeat (100) cyc();
    init_cfg = 1;
    cyc();
    chk1("t1_ready_on_init", req0_ready, 1'b1);
    cyc();
    chk1("t1_wr_start", wr_start_en, 1'b1);
    chk("t1_wr_addr", wr_sec_addr, TEST_SEC_ADDR);
    drain(300);

    // Table: after the first job last_grant points at requester 0
    vecs[0] = '{1, 1'b1, 32'd2000, 1, 1'b0, 32'd2001, 4, 5, 1, 0, 0};
    vecs[1] = '{0, 1'b0, 32'd0, 1, 1'b0, 32'd3000, 0, 1, 1, 0, 0};
    vecs[2] = '{1, 1'b1, 32'd4000, 0, 1'b0, 32'd0, 20, 5, 0, 1, 1};
    vecs[3] = '{1, 1'b1, 32'd5000, 1, 1'b1, 32'd5001, 2, 60, 1, 1, 1};
    vecs[4] = '{1, 1'b0, 32'd6000, 1, 1'b1, 32'd6001, 15, 50, 1, 0, 1};
    vecs[5] = '{1, 1'b0, 32'd7000, 0, 1'b0, 32'd0, 16, 3, 0, 1, 1};
    for (int i = 0; i < 6; i++) begin
      acc_log.delete(); out_err.delete();
      cfg_d = vecs[i].d; cfg_l = vecs[i].l;
      if (vecs[i].v0) push(0, vecs[i].wr0, vecs[i].a0);
      if (vecs[i].v1) push(1, vecs[i].wr1, vecs[i].a1);
      drain(400);
      chk("tbl_first_id", (acc_log.size() > 0) ? 32'(acc_log[0]) : 32'hFFFF, 32'(vecs[i].exp_first));
      chk1("tbl_first_err", (out_err.size() > 0) ? out_err[0] : 1'bx, vecs[i].exp_err);
      chk1("tbl_error_flag", error_flag, vecs[i].exp_flag);
    end

    // Both held valid for four jobs: grants alternate starting with req1
    alt_exp = '{1, 0, 1, 0};
    acc_log.delete();
    cfg_d = 1; cfg_l = 2;
    push(0, 1'b1, 32'd100); push(0, 1'b0, 32'd101);
    push(1, 1'b0, 32'd200); push(1, 1'b1, 32'd201);
    drain(400);
    for (int i = 0; i < 4; i++)
      chk("alt_grant", (acc_log.size() > i) ? 32'(acc_log[i]) : 32'hFFFF, 32'(alt_exp[i]));

    // Card lost mid-transfer
    out_err.delete();
    cfg_d = 1; cfg_l = 1000;
    push(0, 1'b1, 32'd8000);
    repeat (20) cyc();
    init_cfg = 0;
    cyc();
    init_cfg = 1;
    drain(200);
    chk1("init_drop_err", (out_err.size() > 0) ? out_err[0] : 1'bx, 1'b1);

    // Reset in the middle of a transfer
    push(0, 1'b1, 32'd9000);
    repeat (10) cyc();
    #3 reset_n = 1'b0;
    #1;
    chk1("arst_wr_start", wr_start_en, 1'b0);
    chk1("arst_done_err", req0_done | req1_done | req0_err | req1_err, 1'b0);
    chk1("arst_error_flag", error_flag, 1'b0);
    chk("arst_wr_addr", wr_sec_addr, 32'd0);
    chk("arst_rd_addr", rd_sec_addr, 32'd0);
    m_active = 0; m_last = 1; m_sticky = 0; m_wa = '0; m_ra = '0;
    q0.delete(); q1.delete();
    req0_valid = 0; req1_valid = 0; wr_busy = 0; rd_busy = 0;
    repeat (2) @(posedge clk_50m);
    #5 reset_n = 1'b1;
    acc_log.delete();
    cfg_d = 3; cfg_l = 4;
    push(0, 1'b1, TEST_SEC_ADDR);
    push(1, 1'b0, 32'd2001);
    drain(300);
    chk("post_rst_tie", (acc_log.size() > 0) ? 32'(acc_log[0]) : 32'hFFFF, 32'd0);

    // Randomised jobs against the job-level model
    rand_busy = 1;
    for (int k = 0; k < 40; k++) begin
      push(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      repeat ($urandom_range(0, 30)) cyc();
    end
    drain(6000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
